spi_slave: RTL and testbench
============================

# spi_slave

Byte-oriented SPI slave (target) for the serial side of a link whose initiator is the team's `spi_master`. It is fully synchronous to the local clock: it oversamples `sclk`, `ss_n` and `mosi`, supports all four CPOL/CPHA modes, and exchanges one byte per eight SPI clocks. It sits between off-chip or on-chip SPI pins and a local byte-wide register or FIFO interface.

## Interface
- Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`, `ss_n` and `mosi`; legal range 2–3.
- Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpol`  in  1  SPI clock idle level; quasi-static, latched at frame start.
- `cpha`  in  1  0 = sample on the leading edge, 1 = sample on the trailing edge; latched at frame start.
- `sclk`  in  1  SPI clock from the master; asynchronous to `clk`.
- `ss_n`  in  1  slave select, active-low; asynchronous.
- `mosi`  in  1  serial data from the master.
- `miso`  out  1  serial data to the master.
- `miso_oe`  out  1  MISO output enable; high while the slave is selected.
- `din`  in  8  byte to transmit next.
- `din_load`  in  1  single-cycle strobe; captures `din` into the TX holding register.
- `dout`  out  8  last complete received byte.
- `dout_valid`  out  1  single-cycle pulse when `dout` updates.
- `busy`  out  1  high while a frame is active.
- `overrun`  out  1  sticky; set when a byte starts with no fresh `din_load`; cleared by `din_load`.

## Operation
- `sclk`, `ss_n` and `mosi` each pass through `SYNC_STAGES` flops. A registered copy of the synchronized `sclk` provides edge detection.
- Leading edge is the transition away from `cpol`; trailing edge is the transition back to `cpol`.
- The FSM has two states: IDLE and ACTIVE.
- IDLE → ACTIVE on a synchronized `ss_n` fall. On this transition the block:
  - latches `cpol`/`cpha`;
  - loads the shift register from the TX holding register;
  - clears the bit counter;
  - asserts `busy` and `miso_oe`.
- ACTIVE → IDLE on a synchronized `ss_n` rise. A partial byte (bit counter ≠ 0) is discarded and `dout_valid` does not fire.
- `miso` always drives shift-register bit 7, MSB first.
- With `cpha=0`:
  - sample `mosi` on the leading edge;
  - shift out the next bit on the trailing edge;
  - the first bit is valid from frame start.
- With `cpha=1`:
  - shift out on the leading edge; the first leading edge presents bit 7 and does not shift;
  - sample on the trailing edge.
- Bit counter is 3 bits and wraps 7→0.
- When the 8th sample is taken, the block:
  - transfers the received byte to `dout` and pulses `dout_valid`;
  - reloads the shift register from the TX holding register for the next byte (back-to-back bytes within one frame are allowed).
- TX holding register:
  - written by `din_load` in any state;
  - a "fresh" flag is set by `din_load` and cleared by each shift-register load;
  - loading while the flag is clear retransmits the stale value and sets `overrun`;
  - if `din_load` and a load occur in the same cycle, the new `din` is used and `overrun` is not set.
- Sclk edges seen while IDLE are ignored.

## Timing
- All outputs reset to 0: `miso`, `miso_oe`, `dout`, `dout_valid`, `busy`, `overrun`. The TX holding register resets to 8'h00.
- Input-to-action latency is `SYNC_STAGES`+1 `clk` cycles from a pin edge to the internal action.
- `miso` changes at most `SYNC_STAGES`+1 cycles after the shifting `sclk` edge.
- Requirements on the master:
  - each `sclk` half-period ≥ `SYNC_STAGES`+2 `clk` cycles;
  - ≥ `SYNC_STAGES`+2 cycles from `ss_n` fall to the first `sclk` edge;
  - ≥ `SYNC_STAGES`+2 cycles from the last edge to `ss_n` rise.
- `dout_valid` rises `SYNC_STAGES`+2 cycles after the 8th sampling edge on the pin.
- `busy` rises and falls `SYNC_STAGES`+1 cycles after the corresponding `ss_n` pin edge.
- Asserting `rst_n` low mid-frame returns immediately to IDLE with all outputs at their reset values. After `rst_n` releases while `ss_n` is low, the block waits for an `ss_n` rise and then a fall before starting a frame.

## Configuration
- Macro: `SPI_SLAVE_MISO_TRISTATE_EN`.
- Defined: `miso` drives 1'bz whenever `miso_oe` is 0, including during reset. `miso_oe` is still output.
- Undefined: `miso` drives 0 when not enabled, and external logic uses `miso_oe` to gate the pad.

## Test plan
- Mode 0, `din_load` 8'hb2, master sends 8'ha1 → `dout`=8'ha1 with one `dout_valid` pulse; master receives 8'hb2; `busy` 0 after `ss_n` rises; `overrun` 0.
- Repeat for modes 1, 2 and 3 with master/slave byte pairs 8'h51/8'h62 and 8'ha1/8'hb2 → all bytes match in both directions.
- Two-byte frame, slave bytes 8'h11 then 8'h22 (second loaded after the first `dout_valid`), master sends 8'hc3, 8'h3c → two `dout_valid` pulses with 8'hc3 then 8'h3c; master receives 8'h11, 8'h22.
- Second byte with no `din_load` → 8'h11 is retransmitted and `overrun`=1; the next `din_load` clears it.
- `ss_n` rises after 5 bits → no `dout_valid` and `dout` unchanged; the next full frame sends 8'h5a and receives it correctly.
- `rst_n` pulsed low mid-frame → all outputs 0 and `miso` is z (macro defined); a frame after reselect completes correctly.

Source files
------------

// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI target, oversampled on the local clock.
// Supports all four CPOL/CPHA modes and back-to-back bytes within a frame.
// Optional build macro SPI_SLAVE_MISO_TRISTATE_EN: when defined, miso floats
// (1'bz) whenever miso_oe is low; otherwise miso is driven low when disabled.
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] din,
  input  logic       din_load,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_n_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_n_prev_q;

  state_t     state_q, state_d;
  logic       cpol_q, cpol_d, cpha_q, cpha_d;
  logic [7:0] tx_q, tx_d, rx_q, rx_d, hold_q, hold_d, dout_q, dout_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       fresh_q, fresh_d, stale_q, stale_d;
  logic       byte_done_q, byte_done_d, dout_valid_q, dout_valid_d;
  logic       busy_q, busy_d, miso_oe_q, miso_oe_d, overrun_q, overrun_d;

  logic sclk_s, ss_n_s, mosi_s;
  logic sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise, load, first_sample_stale, reload_window;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ss_n_s = ss_n_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_edge   = sclk_s ^ sclk_prev_q;
  assign lead_edge   = sclk_edge & (sclk_s != cpol_q);
  assign trail_edge  = sclk_edge & (sclk_s == cpol_q);
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  // A shift never happens at bit count 0: in CPHA=1 the first leading edge only
  // presents bit 7, and in CPHA=0 the trailing edge after the 8th sample must
  // not disturb the freshly reloaded byte.
  assign shift_edge  = (cpha_q ? lead_edge : trail_edge) & (bit_cnt_q != 3'd0);
  assign ss_fall     = ss_n_prev_q & ~ss_n_s;
  assign ss_rise     = ~ss_n_prev_q & ss_n_s;

  // The first sample of a byte marks the point where a stale reload becomes
  // an overrun; before that a late din_load may still replace the byte.
  assign first_sample_stale = (state_q == ACTIVE) & ~ss_rise & sample_edge &
                              (bit_cnt_q == 3'd0) & stale_q;
  assign reload_window      = (state_q == ACTIVE) & ~ss_rise & stale_q &
                              ~first_sample_stale;

  // Synchronizers reset low so a select held low across reset is never seen as a fall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ss_n_sync_q <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_n_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_n_sync_q <= {ss_n_sync_q[SYNC_STAGES-2:0], ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      ss_n_prev_q <= ss_n_s;
    end
  end

  // Next-state logic: frame control, shifting, sampling and TX holding register
  always_comb begin
    state_d      = state_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    bit_cnt_d    = bit_cnt_q;
    fresh_d      = fresh_q;
    stale_d      = stale_q;
    byte_done_d  = 1'b0;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    miso_oe_d    = miso_oe_q;
    overrun_d    = overrun_q;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = ACTIVE;
          cpol_d    = cpol;
          cpha_d    = cpha;
          bit_cnt_d = 3'd0;
          busy_d    = 1'b1;
          miso_oe_d = 1'b1;
          load      = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else begin
          if (shift_edge) begin
            tx_d = {tx_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            rx_d      = {rx_q[6:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              load        = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (byte_done_q) begin
      dout_d       = rx_q;
      dout_valid_d = 1'b1;
    end

    if (load) begin
      tx_d    = din_load ? din : hold_q;
      stale_d = ~din_load & ~fresh_q;
      fresh_d = 1'b0;
      if (din_load) begin
        hold_d    = din;
        overrun_d = 1'b0;
      end
    end else if (din_load) begin
      hold_d    = din;
      overrun_d = 1'b0;
      if (reload_window) begin
        tx_d    = din;
        stale_d = 1'b0;
      end else begin
        fresh_d = 1'b1;
      end
    end

    if (first_sample_stale) begin
      stale_d   = 1'b0;
      overrun_d = 1'b1;
    end
  end

  // Single state register for the FSM and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      tx_q         <= 8'h00;
      rx_q         <= 8'h00;
      hold_q       <= 8'h00;
      dout_q       <= 8'h00;
      bit_cnt_q    <= 3'd0;
      fresh_q      <= 1'b0;
      stale_q      <= 1'b0;
      byte_done_q  <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      miso_oe_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      bit_cnt_q    <= bit_cnt_d;
      fresh_q      <= fresh_d;
      stale_q      <= stale_d;
      byte_done_q  <= byte_done_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      miso_oe_q    <= miso_oe_d;
      overrun_q    <= overrun_d;
    end
  end

  assign miso_oe    = miso_oe_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = miso_oe_q ? tx_q[7] : 1'bz;
`else
  assign miso = miso_oe_q & tx_q[7];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as the SPI master,
// covering all four modes, multi-byte frames, overrun, aborted frames and reset.
module tb_spi_slave;

  localparam int H = 8;

  logic       clk, rst_n, cpol, cpha, sclk, ss_n, mosi;
  logic       miso, miso_oe, din_load, dout_valid, busy, overrun;
  logic [7:0] din, dout;

  int check_count = 0;
  int err_count   = 0;
  int valid_count = 0;

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk),
    .ss_n(ss_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe), .din(din),
    .din_load(din_load), .dout(dout), .dout_valid(dout_valid), .busy(busy),
    .overrun(overrun)
  );

  // Free-running system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count dout_valid pulses, sampled away from the active edge
  always @(negedge clk) begin
    if (dout_valid) valid_count++;
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic loadDin(input logic [7:0] value);
    din      = value;
    din_load = 1'b1;
    @(negedge clk);
    din_load = 1'b0;
  endtask

  task automatic startFrame(input logic p, input logic h);
    cpol = p;
    cpha = h;
    sclk = p;
    waitCycles(H);
    ss_n = 1'b0;
    waitCycles(H);
  endtask

  task automatic endFrame();
    ss_n = 1'b1;
    waitCycles(H);
  endtask

  // Master side of nbits bit periods, MSB first; returns what came back on miso
  task automatic xferBits(input logic [7:0] m, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = m[7-i];
        waitCycles(H);
        sclk = ~cpol;
        r = {r[6:0], miso};
        waitCycles(H);
        sclk = cpol;
      end else begin
        waitCycles(H);
        sclk = ~cpol;
        mosi = m[7-i];
        waitCycles(H);
        sclk = cpol;
        r = {r[6:0], miso};
      end
    end
    waitCycles(H);
  endtask

  // One single-byte frame in a given mode, fully checked
  task automatic applyStimulus(input logic p, input logic h, input logic [7:0] m, input logic [7:0] s);
    logic [7:0] r;
    int base;
    string mode;
    mode = $sformatf("mode%0d", {p, h});
    loadDin(s);
    base = valid_count;
    startFrame(p, h);
    checkOutput({mode, "_busy_on"}, {7'b0, busy}, 8'h01);
    checkOutput({mode, "_oe_on"}, {7'b0, miso_oe}, 8'h01);
    xferBits(m, 8, r);
    endFrame();
    checkOutput({mode, "_dout"}, dout, m);
    checkOutput({mode, "_master_rx"}, r, s);
    checkOutput({mode, "_valid_pulses"}, 8'(valid_count - base), 8'd1);
    checkOutput({mode, "_busy_off"}, {7'b0, busy}, 8'h00);
    checkOutput({mode, "_overrun"}, {7'b0, overrun}, 8'h00);
  endtask

  logic [7:0] idle_miso;
  logic [7:0] r1, r2;
  int base;

  initial begin
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    idle_miso = 8'b0000000z;
`else
    idle_miso = 8'h00;
`endif
    rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; sclk = 1'b0; ss_n = 1'b1;
    mosi = 1'b0; din = 8'h00; din_load = 1'b0;
    waitCycles(3);
    checkOutput("rst_dout", dout, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    checkOutput("rst_oe", {7'b0, miso_oe}, 8'h00);
    checkOutput("rst_overrun", {7'b0, overrun}, 8'h00);
    checkOutput("rst_valid", {7'b0, dout_valid}, 8'h00);
    checkOutput("rst_miso", {7'b0, miso}, idle_miso);
    rst_n = 1'b1;
    waitCycles(5);

    applyStimulus(1'b0, 1'b0, 8'ha1, 8'hb2);
    applyStimulus(1'b0, 1'b1, 8'h51, 8'h62);
    applyStimulus(1'b1, 1'b0, 8'ha1, 8'hb2);
    applyStimulus(1'b1, 1'b1, 8'h51, 8'h62);

    // Two-byte frame, second byte loaded after the first completes
    loadDin(8'h11);
    base = valid_count;
    startFrame(1'b0, 1'b0);
    xferBits(8'hc3, 8, r1);
    checkOutput("two_dout1", dout, 8'hc3);
    loadDin(8'h22);
    xferBits(8'h3c, 8, r2);
    endFrame();
    checkOutput("two_rx1", r1, 8'h11);
    checkOutput("two_rx2", r2, 8'h22);
    checkOutput("two_dout2", dout, 8'h3c);
    checkOutput("two_valid_pulses", 8'(valid_count - base), 8'd2);
    checkOutput("two_overrun", {7'b0, overrun}, 8'h00);

    // Second byte without a fresh load retransmits and flags overrun
    loadDin(8'h11);
    startFrame(1'b0, 1'b1);
    xferBits(8'ha5, 8, r1);
    xferBits(8'h96, 8, r2);
    endFrame();
    checkOutput("ovr_rx1", r1, 8'h11);
    checkOutput("ovr_rx2", r2, 8'h11);
    checkOutput("ovr_dout", dout, 8'h96);
    checkOutput("ovr_set", {7'b0, overrun}, 8'h01);
    loadDin(8'h77);
    checkOutput("ovr_clear", {7'b0, overrun}, 8'h00);

    // Frame aborted after five bits leaves dout untouched
    base = valid_count;
    startFrame(1'b0, 1'b0);
    xferBits(8'hff, 5, r1);
    endFrame();
    checkOutput("part_valid_pulses", 8'(valid_count - base), 8'd0);
    checkOutput("part_dout", dout, 8'h96);
    loadDin(8'h5a);
    base = valid_count;
    startFrame(1'b0, 1'b0);
    xferBits(8'h5a, 8, r1);
    endFrame();
    checkOutput("after_part_dout", dout, 8'h5a);
    checkOutput("after_part_rx", r1, 8'h5a);
    checkOutput("after_part_valid", 8'(valid_count - base), 8'd1);

    // Reset in the middle of a frame
    loadDin(8'hc5);
    startFrame(1'b0, 1'b0);
    xferBits(8'hf0, 3, r1);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("midrst_busy", {7'b0, busy}, 8'h00);
    checkOutput("midrst_oe", {7'b0, miso_oe}, 8'h00);
    checkOutput("midrst_dout", dout, 8'h00);
    checkOutput("midrst_valid", {7'b0, dout_valid}, 8'h00);
    checkOutput("midrst_overrun", {7'b0, overrun}, 8'h00);
    checkOutput("midrst_miso", {7'b0, miso}, idle_miso);
    rst_n = 1'b1;
    waitCycles(2 * H);
    checkOutput("post_rst_no_frame", {7'b0, busy}, 8'h00);
    endFrame();
    loadDin(8'hc5);
    base = valid_count;
    startFrame(1'b0, 1'b1);
    xferBits(8'h3c, 8, r1);
    endFrame();
    checkOutput("reselect_dout", dout, 8'h3c);
    checkOutput("reselect_rx", r1, 8'hc5);
    checkOutput("reselect_valid", 8'(valid_count - base), 8'd1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
